// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - opcode / function-field constants of the supported instructions
//   - FSM state encoding (also visible on the debug "state" port)
//   - instruction classes produced by the decoder
//   - select / operation codes driven towards the datapath and the MDU
package mips_mc_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;

    // FSM states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXE_R    = 4'd2,
        S_WB_R     = 4'd3,
        S_EXE_I    = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_WR   = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_MD       = 4'd12
    } state_t;

    // Instruction classes, one per execution path through the FSM
    typedef enum logic [2:0] {
        CL_ILL = 3'd0,
        CL_R   = 3'd1,
        CL_I   = 3'd2,
        CL_MEM = 3'd3,
        CL_BR  = 3'd4,
        CL_JMP = 3'd5,
        CL_MD  = 3'd6
    } cls_t;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT  = 2'd0;
    localparam logic [1:0] SRCB_IMM = 2'd1;
    localparam logic [1:0] SRCB_4   = 2'd2;

    // Destination register select
    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    // Register-file write-data select
    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_MEM  = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;
    localparam logic [1:0] WD_HILO = 2'd3;

    // Next-PC select
    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_J   = 2'd2;
    localparam logic [1:0] PC_JR  = 2'd3;

    // MDU operations
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MFHI  = 3'd4;
    localparam logic [2:0] MD_MFLO  = 3'd5;

    // Decoder result
    typedef struct packed {
        cls_t       cls;
        logic [2:0] alu_op;   // ALU operation for R/I-type execute
        logic       is_sw;
        logic       is_lwrr;
        logic       is_jal;
        logic       is_jr;
        logic       is_mfx;   // mfhi/mflo: reads HI/LO instead of launching
        logic [2:0] md_op;
    } dec_t;

endpackage

// File: rtl/mips_mc_decode.sv
// mips_mc_decode: combinational instruction decoder.
//   op, func : instruction fields from the IR
//   dec      : instruction class plus per-instruction qualifiers and MDU op
// Parameters: LWRR_OP (opcode of LWRR), MDU_EN (0 makes MDU ops illegal).
import mips_mc_pkg::*;

module mips_mc_decode #(
    parameter logic [5:0] LWRR_OP = 6'b110011,
    parameter bit         MDU_EN  = 1'b1
) (
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec
);

    always_comb begin
        dec.cls     = CL_ILL;
        dec.alu_op  = ALU_ADD;
        dec.is_sw   = 1'b0;
        dec.is_lwrr = 1'b0;
        dec.is_jal  = 1'b0;
        dec.is_jr   = 1'b0;
        dec.is_mfx  = 1'b0;
        dec.md_op   = MD_MULT;

        case (op)
            OP_RTYPE: begin
                case (func)
                    F_ADDU:  begin dec.cls = CL_R;   dec.alu_op = ALU_ADD; end
                    F_SUBU:  begin dec.cls = CL_R;   dec.alu_op = ALU_SUB; end
                    F_JR:    begin dec.cls = CL_JMP; dec.is_jr  = 1'b1;    end
                    F_MULT:  begin dec.cls = CL_MD;  dec.md_op  = MD_MULT;  end
                    F_MULTU: begin dec.cls = CL_MD;  dec.md_op  = MD_MULTU; end
                    F_DIV:   begin dec.cls = CL_MD;  dec.md_op  = MD_DIV;   end
                    F_DIVU:  begin dec.cls = CL_MD;  dec.md_op  = MD_DIVU;  end
                    F_MFHI:  begin dec.cls = CL_MD;  dec.md_op  = MD_MFHI; dec.is_mfx = 1'b1; end
                    F_MFLO:  begin dec.cls = CL_MD;  dec.md_op  = MD_MFLO; dec.is_mfx = 1'b1; end
                    default: dec.cls = CL_ILL;
                endcase
            end
            OP_ORI:  begin dec.cls = CL_I;   dec.alu_op = ALU_OR;  end
            OP_LUI:  begin dec.cls = CL_I;   dec.alu_op = ALU_LUI; end
            OP_LW:   dec.cls = CL_MEM;
            OP_SW:   begin dec.cls = CL_MEM; dec.is_sw  = 1'b1; end
            OP_BEQ:  dec.cls = CL_BR;
            OP_J:    dec.cls = CL_JMP;
            OP_JAL:  begin dec.cls = CL_JMP; dec.is_jal = 1'b1; end
            default: begin
                // LWRR lives on a configurable opcode, so it is matched here
                // rather than as a case item that could collide with the above.
                if (op == LWRR_OP) begin
                    dec.cls     = CL_MEM;
                    dec.is_lwrr = 1'b1;
                end
            end
        endcase

        if (MDU_EN == 1'b0 && dec.cls == CL_MD) begin
            dec.cls = CL_ILL;
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle control unit of the MIPS core.
// Sequences fetch / decode / execute / memory / writeback, issues work to the
// multiply/divide unit with a start/busy handshake and counts retired
// instructions.
//   clk, reset          : core clock, synchronous active-high reset
//   op, func            : IR fields
//   zero                : ALU equal flag (beq)
//   md_busy             : MDU busy
//   pc_we..dm_we        : datapath write enables
//   alu_src_b, alu_ctrl, ext_sign, reg_dst, wd_sel, pc_src, lwrr : datapath selects
//   md_start, md_op     : MDU launch pulse and latched operation
//   illegal             : sticky unknown-instruction flag
//   retired             : completed-instruction counter (wraps)
//   state               : current FSM state for debug
// Control outputs are decoded combinationally from the state and IR fields;
// state, retired, illegal and md_op are registered.
import mips_mc_pkg::*;

module mips_mc_ctrl #(
    parameter logic [5:0] LWRR_OP = 6'b110011,
    parameter int         CNT_W   = 32,
    parameter bit         MDU_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             md_busy,
    output logic             pc_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             dm_we,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             ext_sign,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [1:0]       pc_src,
    output logic             lwrr,
    output logic             md_start,
    output logic [2:0]       md_op,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_t           state_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             illegal_reg;
    logic [2:0]       md_op_reg;
    dec_t             dec;
    logic             done;   // current cycle completes an instruction

    mips_mc_decode #(
        .LWRR_OP (LWRR_OP),
        .MDU_EN  (MDU_EN)
    ) u_decode (
        .op   (op),
        .func (func),
        .dec  (dec)
    );

    // Output decode
    always_comb begin
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        dm_we     = 1'b0;
        alu_src_b = SRCB_RT;
        alu_ctrl  = ALU_ADD;
        ext_sign  = 1'b0;
        reg_dst   = RD_RT;
        wd_sel    = WD_ALU;
        pc_src    = PC_SEQ;
        lwrr      = 1'b0;
        md_start  = 1'b0;
        done      = 1'b0;

        case (state_reg)
            S_FETCH: begin
                ir_we  = 1'b1;
                pc_we  = 1'b1;
                pc_src = PC_SEQ;
            end
            S_EXE_R: begin
                alu_src_b = SRCB_RT;
                alu_ctrl  = dec.alu_op;
            end
            S_WB_R: begin
                rf_we   = 1'b1;
                reg_dst = RD_RD;
                wd_sel  = WD_ALU;
                done    = 1'b1;
            end
            S_EXE_I: begin
                alu_src_b = SRCB_IMM;
                ext_sign  = 1'b0;
                alu_ctrl  = dec.alu_op;
            end
            S_WB_I: begin
                rf_we   = 1'b1;
                reg_dst = RD_RT;
                wd_sel  = WD_ALU;
                done    = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_b = SRCB_IMM;
                ext_sign  = 1'b1;
                alu_ctrl  = ALU_ADD;
            end
            S_MEM_WR: begin
                dm_we = 1'b1;
                done  = 1'b1;
            end
            S_MEM_WB: begin
                rf_we   = 1'b1;
                wd_sel  = WD_MEM;
                reg_dst = RD_RT;
                lwrr    = dec.is_lwrr;
                done    = 1'b1;
            end
            S_BRANCH: begin
                alu_ctrl = ALU_SUB;
                ext_sign = 1'b1;
                pc_we    = zero;
                pc_src   = PC_BR;
                done     = 1'b1;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = dec.is_jr ? PC_JR : PC_J;
                if (dec.is_jal) begin
                    rf_we   = 1'b1;
                    reg_dst = RD_RA;
                    wd_sel  = WD_PC4;
                end
                done = 1'b1;
            end
            S_MD: begin
                // Both MDU launches and HI/LO reads wait for an idle MDU.
                if (!md_busy) begin
                    if (dec.is_mfx) begin
                        rf_we   = 1'b1;
                        reg_dst = RD_RD;
                        wd_sel  = WD_HILO;
                    end else begin
                        md_start = 1'b1;
                    end
                    done = 1'b1;
                end
            end
            default: ;
        endcase

        // An instruction interrupted by reset must not commit anything.
        if (reset) begin
            pc_we     = 1'b0;
            ir_we     = 1'b0;
            rf_we     = 1'b0;
            dm_we     = 1'b0;
            alu_src_b = SRCB_RT;
            alu_ctrl  = ALU_ADD;
            ext_sign  = 1'b0;
            reg_dst   = RD_RT;
            wd_sel    = WD_ALU;
            pc_src    = PC_SEQ;
            lwrr      = 1'b0;
            md_start  = 1'b0;
            done      = 1'b0;
        end
    end

    // FSM, retired counter, sticky illegal flag and latched MDU op
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
            illegal_reg <= 1'b0;
            md_op_reg   <= MD_MULT;
        end else begin
            if (done) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end

            case (state_reg)
                S_FETCH:  state_reg <= S_DECODE;
                S_DECODE: begin
                    case (dec.cls)
                        CL_R:    state_reg <= S_EXE_R;
                        CL_I:    state_reg <= S_EXE_I;
                        CL_MEM:  state_reg <= S_MEM_ADDR;
                        CL_BR:   state_reg <= S_BRANCH;
                        CL_JMP:  state_reg <= S_JUMP;
                        CL_MD: begin
                            state_reg <= S_MD;
                            md_op_reg <= dec.md_op;
                        end
                        default: begin
                            illegal_reg <= 1'b1;
                            state_reg   <= S_FETCH;
                        end
                    endcase
                end
                S_EXE_R:    state_reg <= S_WB_R;
                S_EXE_I:    state_reg <= S_WB_I;
                S_MEM_ADDR: state_reg <= dec.is_sw ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   state_reg <= S_MEM_WB;
                S_MD: begin
                    if (!md_busy) begin
                        state_reg <= S_FETCH;
                    end
                end
                default:    state_reg <= S_FETCH;
            endcase
        end
    end

    assign retired = retired_reg;
    assign illegal = illegal_reg;
    assign md_op   = md_op_reg;
    assign state   = 4'(state_reg);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: scoreboard bench for mips_mc_ctrl. Each scenario task
// drives the IR fields / flags one cycle at a time and pushes the outputs it
// expects for that cycle; a monitor pops and compares on the falling edge.
import mips_mc_pkg::*;

module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset, zero, md_busy;
    logic [5:0]  op, func;
    logic        pc_we, ir_we, rf_we, dm_we, ext_sign, lwrr, md_start, illegal;
    logic [1:0]  alu_src_b, reg_dst, wd_sel, pc_src;
    logic [2:0]  alu_ctrl, md_op;
    logic [31:0] retired;
    logic [3:0]  state;

    mips_mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .md_busy(md_busy), .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we),
        .dm_we(dm_we), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .ext_sign(ext_sign), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .pc_src(pc_src), .lwrr(lwrr), .md_start(md_start), .md_op(md_op),
        .illegal(illegal), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic        pc_we, ir_we, rf_we, dm_we;
        logic [1:0]  reg_dst, wd_sel, pc_src;
        logic        lwrr, md_start, illegal;
        logic [31:0] retired;
        bit          chk_srcb, chk_ext, chk_ctrl, chk_md;
        logic [1:0]  alu_src_b;
        logic        ext_sign;
        logic [2:0]  alu_ctrl;
        logic [2:0]  md_op;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_ret = 0;
    logic        exp_ill = 0;

    function automatic exp_t base(input state_t s, input string nm);
        exp_t e;
        e.st = 4'(s);
        e.pc_we = 0; e.ir_we = 0; e.rf_we = 0; e.dm_we = 0;
        e.reg_dst = 0; e.wd_sel = 0; e.pc_src = 0;
        e.lwrr = 0; e.md_start = 0;
        e.illegal = exp_ill; e.retired = exp_ret;
        e.chk_srcb = 0; e.chk_ext = 0; e.chk_ctrl = 0; e.chk_md = 0;
        e.alu_src_b = 0; e.ext_sign = 0; e.alu_ctrl = 0; e.md_op = 0;
        e.name = nm;
        return e;
    endfunction

    // Queue one cycle's expectation, then advance to just after the next edge.
    task automatic push(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t        e;
        logic [48:0] a, x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {state, pc_we, ir_we, rf_we, dm_we, reg_dst, wd_sel, pc_src,
                     lwrr, md_start, illegal, retired};
                x = {e.st, e.pc_we, e.ir_we, e.rf_we, e.dm_we, e.reg_dst, e.wd_sel,
                     e.pc_src, e.lwrr, e.md_start, e.illegal, e.retired};
                tests++;
                if (a !== x) begin
                    fails++;
                    $display("FAIL %s: {st,we,sel,flags,retired} got %h want %h", e.name, a, x);
                end else begin
                    $display("[TB] ok %s state=%0d retired=%0d", e.name, state, retired);
                end
                if (e.chk_srcb) begin
                    tests++;
                    if (alu_src_b !== e.alu_src_b) begin
                        fails++;
                        $display("FAIL %s alu_src_b: got %0d want %0d", e.name, alu_src_b, e.alu_src_b);
                    end
                end
                if (e.chk_ext) begin
                    tests++;
                    if (ext_sign !== e.ext_sign) begin
                        fails++;
                        $display("FAIL %s ext_sign: got %0d want %0d", e.name, ext_sign, e.ext_sign);
                    end
                end
                if (e.chk_ctrl) begin
                    tests++;
                    if (alu_ctrl !== e.alu_ctrl) begin
                        fails++;
                        $display("FAIL %s alu_ctrl: got %0d want %0d", e.name, alu_ctrl, e.alu_ctrl);
                    end
                end
                if (e.chk_md) begin
                    tests++;
                    if (md_op !== e.md_op) begin
                        fails++;
                        $display("FAIL %s md_op: got %0d want %0d", e.name, md_op, e.md_op);
                    end
                end
            end
        end
    endtask

    task automatic do_fetch(input logic [5:0] o, input logic [5:0] f);
        exp_t e;
        op = o; func = f; zero = 1'b0;
        e = base(S_FETCH, "fetch");
        e.ir_we = 1; e.pc_we = 1;
        push(e);
    endtask

    task automatic do_decode();
        push(base(S_DECODE, "decode"));
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 0; func = 0; zero = 0; md_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
        tests++;
        if (retired !== 32'd0) begin fails++; $display("FAIL reset_retired: got %0d want 0", retired); end
        tests++;
        if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %0d want 0", illegal); end
        tests++;
        if ({pc_we, ir_we, rf_we, dm_we, md_start, lwrr} !== 6'b0) begin
            fails++;
            $display("FAIL reset_enables: got %b want 000000", {pc_we, ir_we, rf_we, dm_we, md_start, lwrr});
        end
        tests++;
        if ({alu_src_b, reg_dst, wd_sel, pc_src, alu_ctrl, ext_sign} !== 12'b0) begin
            fails++;
            $display("FAIL reset_selects: got %h want 000", {alu_src_b, reg_dst, wd_sel, pc_src, alu_ctrl, ext_sign});
        end
        $display("[TB] reset checked");
        reset = 1'b0;
        exp_ret = 0; exp_ill = 0;
    endtask

    task automatic test_rtype(input logic [5:0] f, input string nm);
        exp_t e;
        do_fetch(6'h00, f);
        do_decode();
        push(base(S_EXE_R, {nm, "_exe"}));
        e = base(S_WB_R, {nm, "_wb"});
        e.rf_we = 1; e.reg_dst = 1; e.wd_sel = 0;
        push(e);
        exp_ret++;
    endtask

    task automatic test_itype(input logic [5:0] o, input string nm);
        exp_t e;
        do_fetch(o, 6'h15);
        do_decode();
        e = base(S_EXE_I, {nm, "_exe"});
        e.chk_srcb = 1; e.alu_src_b = 1; e.chk_ext = 1; e.ext_sign = 0;
        push(e);
        e = base(S_WB_I, {nm, "_wb"});
        e.rf_we = 1; e.reg_dst = 0; e.wd_sel = 0;
        push(e);
        exp_ret++;
    endtask

    task automatic test_load(input logic [5:0] o, input logic is_lwrr, input string nm);
        exp_t e;
        do_fetch(o, 6'h00);
        do_decode();
        e = base(S_MEM_ADDR, {nm, "_addr"});
        e.chk_srcb = 1; e.alu_src_b = 1; e.chk_ext = 1; e.ext_sign = 1;
        e.chk_ctrl = 1; e.alu_ctrl = 0;
        push(e);
        push(base(S_MEM_RD, {nm, "_rd"}));
        e = base(S_MEM_WB, {nm, "_wb"});
        e.rf_we = 1; e.wd_sel = 1; e.reg_dst = 0; e.lwrr = is_lwrr;
        push(e);
        exp_ret++;
    endtask

    task automatic test_store();
        exp_t e;
        do_fetch(6'h2B, 6'h00);
        do_decode();
        e = base(S_MEM_ADDR, "sw_addr");
        e.chk_srcb = 1; e.alu_src_b = 1; e.chk_ext = 1; e.ext_sign = 1;
        push(e);
        e = base(S_MEM_WR, "sw_wr");
        e.dm_we = 1;
        push(e);
        exp_ret++;
    endtask

    task automatic test_branch(input logic z);
        exp_t e;
        do_fetch(6'h04, 6'h00);
        do_decode();
        zero = z;
        e = base(S_BRANCH, z ? "beq_taken" : "beq_not_taken");
        e.pc_we = z; e.pc_src = 1;
        e.chk_ctrl = 1; e.alu_ctrl = 1; e.chk_ext = 1; e.ext_sign = 1;
        push(e);
        exp_ret++;
    endtask

    task automatic test_jump(input logic [5:0] o, input logic [5:0] f, input string nm);
        exp_t e;
        do_fetch(o, f);
        do_decode();
        e = base(S_JUMP, nm);
        e.pc_we = 1;
        e.pc_src = (o == 6'h00) ? 2'd3 : 2'd2;
        if (o == 6'h03) begin
            e.rf_we = 1; e.reg_dst = 2; e.wd_sel = 2;
        end
        push(e);
        exp_ret++;
    endtask

    task automatic test_md();
        exp_t e;
        // mult behind a busy MDU for five cycles, then a single launch
        do_fetch(6'h00, 6'h18);
        md_busy = 1'b1;
        do_decode();
        for (int i = 0; i < 5; i++) push(base(S_MD, "mult_hold"));
        md_busy = 1'b0;
        e = base(S_MD, "mult_issue");
        e.md_start = 1; e.chk_md = 1; e.md_op = 0;
        push(e);
        exp_ret++;
        // mflo with idle MDU
        do_fetch(6'h00, 6'h12);
        do_decode();
        e = base(S_MD, "mflo");
        e.rf_we = 1; e.reg_dst = 1; e.wd_sel = 3; e.chk_md = 1; e.md_op = 5;
        push(e);
        exp_ret++;
        // div: busy drops exactly as MD is entered, so it issues at once
        do_fetch(6'h00, 6'h1A);
        md_busy = 1'b1;
        do_decode();
        md_busy = 1'b0;
        e = base(S_MD, "div_issue");
        e.md_start = 1; e.chk_md = 1; e.md_op = 2;
        push(e);
        exp_ret++;
        // mfhi waits two busy cycles
        do_fetch(6'h00, 6'h10);
        md_busy = 1'b1;
        do_decode();
        for (int i = 0; i < 2; i++) begin
            e = base(S_MD, "mfhi_hold");
            e.chk_md = 1; e.md_op = 4;
            push(e);
        end
        md_busy = 1'b0;
        e = base(S_MD, "mfhi_wb");
        e.rf_we = 1; e.reg_dst = 1; e.wd_sel = 3; e.chk_md = 1; e.md_op = 4;
        push(e);
        exp_ret++;
    endtask

    task automatic test_illegal();
        do_fetch(6'h3F, 6'h00);
        do_decode();
        exp_ill = 1'b1;          // flag appears from the next FETCH, count unchanged
        test_rtype(6'h21, "addu_after_illegal");
        do_fetch(6'h00, 6'h00);  // R-type with unsupported func
        do_decode();
        tests++;
        if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_sticky: got %0d want 1", illegal); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_fetch(6'h2B, 6'h00);
        do_decode();
        push(base(S_MEM_ADDR, "sw_addr_pre_rst"));
        reset = 1'b1;
        push(base(S_MEM_WR, "rst_in_memwr"));  // dm_we must stay low
        reset = 1'b0;
        exp_ret = 0; exp_ill = 0;
        tests++;
        if (state !== 4'd0 || retired !== 32'd0) begin
            fails++;
            $display("FAIL rst_mid_state: got state=%0d retired=%0d want 0/0", state, retired);
        end
        test_rtype(6'h23, "subu_after_rst");
    endtask

    task automatic test_back_to_back();
        test_rtype(6'h21, "b2b_addu");
        test_jump(6'h02, 6'h00, "b2b_j");
        test_load(6'h23, 1'b0, "b2b_lw");
        test_rtype(6'h23, "b2b_subu");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_rtype(6'h21, "addu");
        test_rtype(6'h23, "subu");
        test_itype(6'h0D, "ori");
        test_itype(6'h0F, "lui");
        test_load(6'h33, 1'b1, "lwrr");
        test_load(6'h23, 1'b0, "lw");
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jump(6'h02, 6'h00, "j");
        test_jump(6'h03, 6'h00, "jal");
        test_jump(6'h00, 6'h08, "jr");
        test_md();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational controller with a registered FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a start/busy handshake to a multiply/divide unit (MDU) whose latency is parametrised.
- Adds a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath inside the core top.

Parameters:
- LWRR_OP, 6'b110011, opcode of the LWRR instruction.
- CNT_W, 32, width of the retired-instruction counter.
- MDU_EN, 1, when 0, MDU opcodes decode as illegal.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- op  in  6  instr[31:26] from IR.
- func  in  6  instr[5:0] from IR.
- zero  in  1  ALU equal flag for beq.
- md_busy  in  1  MDU is computing.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- rf_we  out  1  register file write enable.
- dm_we  out  1  data memory write enable.
- alu_src_b  out  2  0=rt, 1=ext imm, 2=const 4.
- alu_ctrl  out  3  0=add, 1=sub, 2=or, 3=lui.
- ext_sign  out  1  1=sign-extend, 0=zero-extend.
- reg_dst  out  2  0=rt, 1=rd, 2=$31.
- wd_sel  out  2  0=ALU, 1=mem, 2=PC+4, 3=HI/LO.
- pc_src  out  2  0=PC+4, 1=branch, 2=jump, 3=jr.
- lwrr  out  1  LWRR writeback mode to datapath.
- md_start  out  1  one-cycle MDU launch.
- md_op  out  3  0=mult, 1=multu, 2=div, 3=divu, 4=mfhi, 5=mflo.
- illegal  out  1  sticky unknown-opcode flag.
- retired  out  CNT_W  count of completed instructions.
- state  out  4  current state, for debug.

Behaviour:
- Reset (sampled at posedge clk when reset=1):
  - state=FETCH.
  - retired=0, illegal=0.
  - All enables and md_start=0.
  - All selects=0.
  - Reset mid-instruction abandons that instruction; no write enable is asserted in that cycle.
- Outputs are decoded combinationally from state plus the IR fields.
- Registered state:
  - state, retired, illegal.
  - A latched md_op.
- FETCH:
  - ir_we=1, pc_we=1, pc_src=0.
  - Next state DECODE.
- DECODE: dispatch on op/func.
  - addu/subu -> EXE_R.
  - ori/lui -> EXE_I.
  - lw/sw/LWRR -> MEM_ADDR.
  - beq -> BRANCH.
  - j/jal/jr -> JUMP.
  - mult/multu/div/divu/mfhi/mflo -> MD.
  - Anything else -> set illegal=1 and go to FETCH; retired is not incremented.
- EXE_R -> WB_R.
- WB_R:
  - rf_we=1, reg_dst=1, wd_sel=0.
  - Next FETCH.
- EXE_I:
  - alu_src_b=1, ext_sign=0.
  - Next WB_I.
- WB_I:
  - rf_we=1, reg_dst=0, wd_sel=0.
  - Next FETCH.
- MEM_ADDR:
  - alu_src_b=1, ext_sign=1, alu_ctrl=add.
  - sw -> MEM_WR; lw/LWRR -> MEM_RD.
- MEM_WR: dm_we=1; next FETCH.
- MEM_RD: next MEM_WB.
- MEM_WB:
  - rf_we=1, wd_sel=1, reg_dst=0.
  - lwrr=1 for LWRR only.
  - Next FETCH.
- BRANCH:
  - alu_ctrl=sub, ext_sign=1.
  - pc_we=zero, pc_src=1.
  - Next FETCH.
- JUMP:
  - pc_we=1.
  - pc_src=2 for j/jal, 3 for jr.
  - jal additionally asserts rf_we=1, reg_dst=2, wd_sel=2.
  - Next FETCH.
- MD, for mult/multu/div/divu:
  - If md_busy=1, hold in MD with md_start=0.
  - Otherwise md_start=1 for exactly one cycle, then go to FETCH. The issue does not block.
- MD, for mfhi/mflo:
  - Hold while md_busy=1.
  - Then rf_we=1, reg_dst=1, wd_sel=3, and go to FETCH.
- Simultaneous events: reset has priority over every transition. md_busy falling in the same cycle as entering MD allows issue next cycle.
- retired increments by 1 on every transition into FETCH from a completing state, meaning every state except DECODE-illegal and reset. It wraps modulo 2^CNT_W.
- Latency, counted from FETCH to the next FETCH:
  - R-type and I-type: 4 cycles.
  - lw/LWRR: 5 cycles.
  - sw: 4 cycles.
  - beq and jumps: 3 cycles.
  - MD: 3 cycles plus busy cycles.

Decomposition:
- Shared package holds:
  - op/func localparams: OP_RTYPE=0, F_ADDU=6'h21, F_SUBU=6'h23, F_JR=6'h08, F_MULT=6'h18, F_MULTU=6'h19, F_DIV=6'h1A, F_DIVU=6'h1B, F_MFHI=6'h10, F_MFLO=6'h12, OP_ORI=6'h0D, OP_LUI=6'h0F, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_J=6'h02, OP_JAL=6'h03.
  - State encodings.
  - alu_ctrl, wd_sel and pc_src codes.
- One sub-module, mips_mc_decode, is combinational: op/func to instruction class and md_op. The FSM and counter stay in mips_mc_ctrl.

Test Plan:
- addu after reset: op=0, func=6'h21 -> states FETCH, DECODE, EXE_R, WB_R; rf_we=1 and reg_dst=1 in the 4th cycle; retired goes 0->1.
- LWRR with op=6'b110011 -> 5 cycles; lwrr=1, wd_sel=1, rf_we=1 only in MEM_WB.
- beq: zero=1 -> pc_we=1, pc_src=1 in BRANCH. zero=0 -> pc_we=0 in BRANCH. Both cases take 3 cycles.
- mult while md_busy=1 for 5 cycles -> stay in MD with md_start=0 for 5 cycles, then exactly 1 md_start pulse with md_op=0; then mflo with md_busy=0 gives wd_sel=3.
- Unknown op 6'h3F -> illegal=1 stays sticky, retired is unchanged, the next instruction runs normally.
- Reset asserted in MEM_WR -> dm_we=0 in that cycle, state=FETCH next cycle, retired=0.
